// File: rtl/miriscv_pkg.sv
// Shared constants and types for the miriscv fetch path.
package miriscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Registered instruction FIFO with push/pop/flush and full/empty status.
module miriscv_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/miriscv_fetch_unit.sv
// Instruction fetch: issues word requests, buffers in-order responses, and
// discards responses made stale by a redirect.
module miriscv_fetch_unit
  import miriscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        cu_redirect_i,
  input  logic [31:0] cu_redirect_pc_i,
  input  logic        decode_stall_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o
);

  localparam int unsigned    CNT_W      = $clog2(BUF_DEPTH) + 1;
  localparam logic [31:0]    PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W:0] DEPTH_OCC  = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      req_pc_q, req_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] disc_q, disc_d;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head_entry;
  logic [31:0]      redirect_pc;
  logic             unused_redirect_lsbs;

  logic             rvalid_acc, gnt_acc, pop, push, discarding;
  logic [CNT_W:0]   occ;

  assign redirect_pc          = {cu_redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsbs = ^cu_redirect_pc_i[1:0];

  // A response with nothing outstanding belongs to a request killed by reset.
  assign rvalid_acc = instr_rvalid_i && (outst_q != '0);
  assign discarding = (disc_q != '0);
  assign pop        = !fifo_empty && !decode_stall_i;

  // Crediting this cycle's pop keeps a 1-cycle memory streaming at full rate.
  assign occ         = {1'b0, outst_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
  assign instr_req_o = !rst_i && !cu_redirect_i && (occ < DEPTH_OCC);
  assign instr_addr_o = req_pc_q;
  assign gnt_acc     = instr_req_o && instr_gnt_i;
  assign push        = rvalid_acc && !discarding && !cu_redirect_i && !fifo_full;

  assign push_entry = '{instr: instr_rdata_i, pc: resp_pc_q};

  always_comb begin
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    disc_d    = disc_q;
    outst_d   = outst_q + CNT_W'(gnt_acc) - CNT_W'(rvalid_acc);
    if (cu_redirect_i) begin
      req_pc_d  = redirect_pc;
      resp_pc_d = redirect_pc;
      disc_d    = outst_q - CNT_W'(rvalid_acc);
    end else begin
      if (gnt_acc)                  req_pc_d  = req_pc_q + 32'd4;
      if (push)                     resp_pc_d = resp_pc_q + 32'd4;
      if (rvalid_acc && discarding) disc_d    = disc_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q  <= PC_ALIGNED;
      resp_pc_q <= PC_ALIGNED;
      outst_q   <= '0;
      disc_q    <= '0;
    end else begin
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      disc_q    <= disc_d;
    end
  end

  miriscv_fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (cu_redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign fetch_valid_o = !fifo_empty;
  assign fetch_instr_o = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign fetch_pc_o    = fifo_empty ? RESET_PC  : head_entry.pc;

endmodule

// File: doc/miriscv_fetch_unit.md
MIRISCV_FETCH_UNIT -- requirements
Module: miriscv_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the instruction buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk_i  input  1  as the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  as the reset; synchronous and active-high.
REQ-005 SHALL have port instr_req_o  output  1  as the fetch request, accepted in the same cycle when instr_gnt_i=1.
REQ-006 SHALL have port instr_gnt_i  input  1  as the memory grant for instr_req_o.
REQ-007 SHALL have port instr_addr_o  output  32  as the word-aligned fetch address.
REQ-008 SHALL have port instr_rvalid_i  input  1  as the in-order response valid, at least 1 cycle after grant.
REQ-009 SHALL have port instr_rdata_i  input  32  as the response instruction word.
REQ-010 SHALL have port cu_redirect_i  input  1  as the PC redirect request (branch, jump, trap).
REQ-011 SHALL have port cu_redirect_pc_i  input  32  as the redirect target.
REQ-012 SHALL have port decode_stall_i  input  1  indicating that the decoder cannot accept an instruction this cycle.
REQ-013 SHALL have port fetch_valid_o  output  1  indicating that fetch_instr_o/fetch_pc_o hold a valid instruction.
REQ-014 SHALL have port fetch_instr_o  output  32  carrying the instruction presented to miriscv_decoder decode_instr_i.
REQ-015 SHALL have port fetch_pc_o  output  32  carrying the PC of fetch_instr_o.

Function
REQ-016 SHALL hold request PC req_pc; instr_addr_o = {req_pc[31:2],2'b00}; req_pc += 4 on each granted request.
REQ-017 SHALL assert instr_req_o only when (outstanding + buffered) < BUF_DEPTH and no redirect is active this cycle; the instr_req_o term is combinational.
REQ-018 SHALL track outstanding granted-but-unanswered requests in a counter of width clog2(BUF_DEPTH)+1; grant and rvalid in the same cycle leave it unchanged.
REQ-019 SHALL push {rdata, pc} into the FIFO on rvalid unless the discard counter is nonzero; the FIFO cannot overflow because of REQ-017.
REQ-020 SHALL drive fetch_valid_o = FIFO not empty, and fetch_instr_o/fetch_pc_o = head entry; the head pops when fetch_valid_o && !decode_stall_i.
REQ-021 SHALL hold the head stable while decode_stall_i=1.
REQ-022 SHALL handle cu_redirect_i=1 as follows:
  - flush the FIFO;
  - load req_pc with cu_redirect_pc_i;
  - load the discard counter with the current outstanding count (minus 1 if rvalid arrives this cycle);
  - suppress instr_req_o this cycle;
  - the first new request is issued the next cycle.
REQ-023 SHALL decrement the discard counter on each rvalid while it is nonzero and drop that data.
REQ-024 SHALL give a redirect precedence over a simultaneous pop, push or grant; the popped instruction is still consumed by the decoder that cycle.
REQ-025 SHALL, with fetch_valid_o=0 and decode_stall_i=0, have a minimum latency from grant to fetch_valid_o equal to the memory latency plus 1 cycle (registered FIFO).
REQ-026 SHALL sustain 1 instruction/cycle with a 1-cycle memory latency and BUF_DEPTH>=2.
REQ-027 SHALL wrap FIFO pointers modulo BUF_DEPTH and wrap req_pc modulo 2^32.

Reset
REQ-028 SHALL, while rst_i=1, set req_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, fetch_valid_o=0, instr_req_o=0.
REQ-029 SHALL drive fetch_instr_o=32'h0000_0013 (NOP) and fetch_pc_o=RESET_PC while empty after reset.
REQ-030 SHALL discard all in-flight responses on a reset mid-operation; rvalid arriving after reset deassertion with outstanding=0 SHALL be ignored.
REQ-031 SHALL issue the first request in the cycle after rst_i deasserts.

Structure
REQ-032 SHALL place RESET_PC default and the NOP constant (NOP_INSTR) in miriscv_pkg.
REQ-033 SHALL use one sub-module, miriscv_fetch_fifo (parameterised depth/width, push/pop/flush, full/empty).

Verification
REQ-034 SHALL cover: reset, gnt=1, 1-cycle rvalid -> addresses 0,4,8,... and fetch_valid_o first at cycle 3, one instruction per cycle.
REQ-035 SHALL cover: decode_stall_i held for 5 cycles -> at most BUF_DEPTH outstanding+buffered, head unchanged, no lost or duplicated PCs.
REQ-036 SHALL cover: redirect to 32'h0000_0100 with 2 outstanding -> the next 2 responses are dropped and the first valid pc is 0x100.
REQ-037 SHALL cover: redirect in the same cycle as pop and rvalid -> the popped instruction is delivered, the rvalid data is dropped, and the FIFO is empty next cycle.
REQ-038 SHALL cover: gnt=0 for 4 cycles -> instr_addr_o is held and no advance occurs.
REQ-039 SHALL cover: rst_i pulsed with 1 outstanding -> the late rvalid is ignored and fetch restarts at RESET_PC.
